// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_inc.sv
// Sequential-fetch address generator: pc + PC_STEP, wrapping modulo 2^32.
module fetch_pc_inc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);

    assign pc_next = pc + PC_STEP;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one-entry decode hold.
// Latency: ack to inst_valid is 1 cycle; after a redirect the next request issues 1 cycle later.
// Backpressure: stall blocks new requests only; inst held while inst_ready=0. FETCH_CTRL_ALIGN_CHK_EN adds misalign.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_CTRL_ALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d, pc_plus;
    logic [31:0]  pend_pc, pend_pc_d;
    logic [31:0]  inst_d, inst_pc_d;
    logic         drop, drop_d;
    logic         rd_vld;
    logic [31:0]  rd_pc;

`ifdef FETCH_CTRL_ALIGN_CHK_EN
    // Misaligned targets are treated as if no redirect arrived at all.
    assign rd_vld = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign rd_pc  = redirect_pc;
`else
    assign rd_vld = redirect_valid;
    assign rd_pc  = redirect_pc & ~32'h3;
`endif

    fetch_pc_inc u_pc_inc (
        .pc      (pc),
        .pc_next (pc_plus)
    );

    assign imem_req   = (state == S_REQ);
    assign inst_valid = (state == S_HOLD);
    assign imem_addr  = pc;

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        pend_pc_d = pend_pc;
        drop_d    = drop;
        inst_d    = inst;
        inst_pc_d = inst_pc;
        case (state)
            S_IDLE: begin
                if (rd_vld) begin
                    pc_d = rd_pc;
                end else if (!stall) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (rd_vld || drop) begin
                        pc_d    = rd_vld ? rd_pc : pend_pc;
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc;
                        pc_d      = pc_plus;
                        state_d   = S_HOLD;
                    end
                end else if (rd_vld) begin
                    // Address must stay put until the bus completes; remember the target.
                    drop_d    = 1'b1;
                    pend_pc_d = rd_pc;
                end
            end
            S_HOLD: begin
                if (rd_vld) begin
                    pc_d    = rd_pc;
                    state_d = S_IDLE;
                end else if (inst_ready) begin
                    state_d = stall ? S_IDLE : S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            pend_pc <= 32'h0;
            drop    <= 1'b0;
            inst    <= 32'h0;
            inst_pc <= 32'h0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            pend_pc <= pend_pc_d;
            drop    <= drop_d;
            inst    <= inst_d;
            inst_pc <= inst_pc_d;
        end
    end

`ifdef FETCH_CTRL_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (redirect_valid) begin
            misalign <= (redirect_pc[1:0] != 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl, plus a wrap-around instance started at 0xFFFF_FFFC.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_inst, w_inst_pc;

`ifdef FETCH_CTRL_ALIGN_CHK_EN
    logic        misalign;
    logic        w_misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sb_inst[$];
    logic [31:0] sb_pc[$];
    logic [31:0] w_exp[$];

    fetch_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_CTRL_ALIGN_CHK_EN
        ,
        .misalign       (misalign)
`endif
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .stall          (1'b0),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (w_req),
        .imem_rdata     (w_addr),
        .inst_valid     (w_valid),
        .inst           (w_inst),
        .inst_pc        (w_inst_pc),
        .inst_ready     (1'b1)
`ifdef FETCH_CTRL_ALIGN_CHK_EN
        ,
        .misalign       (w_misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wrap instance: ack in the request cycle, addresses must run FFFF_FFFC, 0, 4.
    always @(negedge clk) begin
        if (!rst && w_req && w_exp.size() != 0) begin
            chk("wrap_addr", w_addr, w_exp.pop_front());
        end
    end

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", imem_req, 1);
        chk("req_addr", imem_addr, exp_addr);
    endtask

    task automatic serve(input logic [31:0] exp_addr, input int dly);
        wait_req(exp_addr);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("addr_stable", imem_addr, exp_addr);
            chk("req_held", imem_req, 1);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(exp_addr);
        sb_inst.push_back(mem_word(exp_addr));
        sb_pc.push_back(exp_addr);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic take();
        int n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        chk("inst_valid", inst_valid, 1);
        chk("sb_nonempty", sb_inst.size() != 0, 1);
        if (sb_inst.size() != 0) begin
            chk("inst", inst, sb_inst.pop_front());
            chk("inst_pc", inst_pc, sb_pc.pop_front());
        end
    endtask

    logic [31:0] exp_after_mis;
    logic [31:0] good_target;

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b1;
        w_exp.push_back(32'hFFFF_FFFC);
        w_exp.push_back(32'h0000_0000);
        w_exp.push_back(32'h0000_0004);
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_CTRL_ALIGN_CHK_EN
        chk("rst_misalign", misalign, 0);
`endif
        rst = 1'b0;
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);

        // Sequential stream.
        serve(32'h0, 0);
        take();
        serve(32'h4, 0);
        take();

        // Redirect while 0x8 is outstanding; the late response must be dropped.
        wait_req(32'h8);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("drop_addr_held", imem_addr, 32'h8);
        chk("drop_req_held", imem_req, 1);
        tick();
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0008;
        tick();
        imem_ack = 1'b0;
        chk("drop_no_valid", inst_valid, 0);
        serve(32'h100, 0);
        take();

        // Decode backpressure for 4 cycles, then redirect beats inst_ready.
        serve(32'h104, 0);
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", inst_valid, 1);
            chk("hold_inst", inst, mem_word(32'h104));
            chk("hold_inst_pc", inst_pc, 32'h104);
            chk("hold_no_req", imem_req, 0);
        end
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        void'(sb_inst.pop_front());
        void'(sb_pc.pop_front());
        chk("redir_hold_drop", inst_valid, 0);
        serve(32'h40, 0);
        take();

        // Redirect coincident with ack, then stall across an outstanding request.
        wait_req(32'h44);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hBAD0_0044;
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        chk("ack_redir_valid", inst_valid, 0);
        chk("ack_redir_req", imem_req, 0);
        wait_req(32'h10);
        stall = 1'b1;
        tick();
        chk("stall_req_kept", imem_req, 1);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h10);
        sb_inst.push_back(mem_word(32'h10));
        sb_pc.push_back(32'h10);
        tick();
        imem_ack = 1'b0;
        take();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_req", imem_req, 0);
        end
        stall = 1'b0;
        serve(32'h14, 1);
        take();
        stall = 1'b1;
        tick();

        // Misaligned redirect handling.
`ifdef FETCH_CTRL_ALIGN_CHK_EN
        exp_after_mis = 32'h18;
        good_target   = 32'h200;
`else
        exp_after_mis = 32'h100;
        good_target   = 32'h202;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_CTRL_ALIGN_CHK_EN
        chk("misalign_set", misalign, 1);
`endif
        stall = 1'b0;
        wait_req(exp_after_mis);
        redirect_valid = 1'b1;
        redirect_pc    = good_target;
        tick();
        redirect_valid = 1'b0;
        chk("mis_addr_held", imem_addr, exp_after_mis);
`ifdef FETCH_CTRL_ALIGN_CHK_EN
        chk("misalign_clr", misalign, 0);
`endif
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0000;
        tick();
        imem_ack = 1'b0;
        chk("mis_drop_valid", inst_valid, 0);
        serve(32'h200, 0);
        take();

        // Reset with a coincident ack abandons the request.
        wait_req(32'h204);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0204;
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        chk("mrst_req", imem_req, 0);
        chk("mrst_valid", inst_valid, 0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_inst", inst, 32'h0);
        chk("mrst_inst_pc", inst_pc, 32'h0);
        wait_req(32'h0);

        chk("sb_empty", sb_inst.size(), 0);
        chk("wrap_done", w_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port redirect_valid  input  1  SHALL indicate a branch/jump target this cycle.
REQ-005 Port redirect_pc  input  32  SHALL carry the redirect target.
REQ-006 Port stall  input  1  SHALL, when 1, block issue of new fetch requests.
REQ-007 Port imem_req  output  1  SHALL be the instruction-memory request.
REQ-008 Port imem_addr  output  32  SHALL be the fetch address.
REQ-009 Port imem_ack  input  1  SHALL mark request completion, with imem_rdata valid that cycle.
REQ-010 Port imem_rdata  input  32  SHALL carry the fetched word.
REQ-011 Port inst_valid  output  1  SHALL mark a valid instruction for decode.
REQ-012 Port inst  output  32  SHALL carry the instruction word.
REQ-013 Port inst_pc  output  32  SHALL carry that instruction's address.
REQ-014 Port inst_ready  input  1  SHALL mark decode accepting inst.

Function
REQ-015 FSM states SHALL be S_IDLE, S_REQ, S_HOLD; imem_req=1 only in S_REQ; inst_valid=1 only in S_HOLD.
REQ-016 Internal pc register SHALL drive imem_addr; imem_addr SHALL be stable while imem_req=1 and imem_ack=0.
REQ-017 S_IDLE: redirect_valid -> pc<=redirect_pc, stay S_IDLE; else stall=0 -> S_REQ; else stay.
REQ-018 S_REQ, imem_ack=1, no redirect this cycle, drop flag clear: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, -> S_HOLD.
REQ-019 S_REQ, imem_ack=0, redirect_valid=1: drop flag<=1, pend_pc<=redirect_pc (later redirect overwrites earlier), stay S_REQ, address unchanged.
REQ-020 S_REQ, imem_ack=1 with redirect_valid=1 or drop flag set: response discarded, pc<=redirect_pc if redirect_valid else pend_pc, drop flag<=0, -> S_IDLE.
REQ-021 S_HOLD: redirect_valid=1 -> instruction discarded, pc<=redirect_pc, -> S_IDLE (redirect wins over inst_ready same cycle).
REQ-022 S_HOLD, inst_ready=1, no redirect: -> S_REQ if stall=0, else S_IDLE; inst/inst_pc held stable while inst_valid=1 and inst_ready=0.
REQ-023 stall SHALL NOT abort an outstanding request; it only prevents entry to S_REQ.
REQ-024 pc+4 SHALL be 32-bit modulo: 32'hFFFF_FFFC -> 32'h0000_0000, no overflow flag.
REQ-025 Latency: first rising edge with rst=0 -> S_REQ with imem_addr=RESET_PC on following cycle (stall=0); ack-to-inst_valid SHALL be 1 cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL force: state S_IDLE, pc=RESET_PC, drop flag 0, pend_pc 0, inst 0, inst_pc 0, inst_valid 0, imem_req 0, misalign 0.
REQ-027 rst mid-request SHALL abandon it; a coincident imem_ack SHALL be ignored.

Configuration
REQ-028 Macro FETCH_CTRL_ALIGN_CHK_EN defined: output misalign (1 bit) exists; redirect with redirect_pc[1:0]!=0 SHALL be ignored (pc, drop flag unchanged) and set misalign=1, held until next aligned redirect or reset.
REQ-029 Macro undefined: no misalign port; redirect_pc[1:0] SHALL be forced to 2'b00 before use.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum, PC_STEP=32'd4 and default RESET_PC constant.
REQ-031 One sub-module fetch_pc_inc SHALL compute the 32-bit pc+PC_STEP; no other sub-modules.

Verification
REQ-032 Reset, stall=0, ack every request in 1 cycle, inst_ready=1 -> imem_addr 0x0,0x4,0x8 in order; inst_pc matches.
REQ-033 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-034 Redirect to 0x100 while S_REQ awaiting ack at 0x8, ack 3 cycles later -> no inst_valid for 0x8; next imem_addr=0x100.
REQ-035 inst_ready=0 for 4 cycles in S_HOLD -> inst/inst_pc stable, no imem_req; redirect+inst_ready same cycle -> inst dropped.
REQ-036 stall=1 during outstanding request at 0x10 -> request completes, inst_valid for 0x10, no new imem_req until stall=0.
REQ-037 With FETCH_CTRL_ALIGN_CHK_EN, redirect to 0x102 -> misalign=1, pc unchanged; then redirect 0x200 -> misalign=0, fetch 0x200.
